iic_master: RTL and testbench

IIC_MASTER -- requirements
Module: iic_master

---
 rtl/iic_pkg.sv | 26 ++
 rtl/iic_master_if.sv | 27 ++
 rtl/iic_clk_gen.sv | 32 +++
 rtl/iic_master.sv | 148 ++++++++++++++
 tb/tb_iic_master.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC master and its target: FSM encoding,
// released-bus SDA level and the default target address.
package iic_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_ADDR   = 4'd2;
    localparam logic [3:0] ST_ACK_A  = 4'd3;
    localparam logic [3:0] ST_WDATA  = 4'd4;
    localparam logic [3:0] ST_ACK_W  = 4'd5;
    localparam logic [3:0] ST_RDATA  = 4'd6;
    localparam logic [3:0] ST_NACK_R = 4'd7;
    localparam logic [3:0] ST_STOP   = 4'd8;
    localparam logic [3:0] ST_DONE   = 4'd9;

    localparam logic       IDLE_SDA     = 1'b1;
    localparam logic [6:0] DEFAULT_ADDR = 7'd69;

    // First byte on the wire: 7-bit address followed by the R/W bit.
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/iic_master_if.sv
// Request/response and bus-pin bundle between the IIC master and its user/target.
interface iic_master_if;

    logic       go;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       SDA_recv;
    logic       SCL;
    logic       grab_SDA;
    logic       SDA_drive;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (
        input  go, rw, addr, wdata, SDA_recv,
        output SCL, grab_SDA, SDA_drive, busy, done, ack_err, rdata
    );

    modport slave (
        output go, rw, addr, wdata, SDA_recv,
        input  SCL, grab_SDA, SDA_drive, busy, done, ack_err, rdata
    );

endinterface

// File: rtl/iic_clk_gen.sv
// Quarter-period tick generator: strobes every CLK_DIV cycles and steps a
// 2-bit quarter phase; held at zero while disabled so each transfer starts aligned.
module iic_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] phase
);

    logic [7:0] cnt;

    assign qtick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 8'd0;
            phase <= 2'd0;
        end else if (!en) begin
            cnt   <= 8'd0;
            phase <= 2'd0;
        end else if (qtick) begin
            cnt   <= 8'd0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/iic_master.sv
// Single-byte IIC master: START, address+R/W, one write or read byte, STOP.
// Bus pins are decoded combinationally from state, bit index and quarter phase.
module iic_master
    import iic_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic          clk,
    input logic          reset,
    iic_master_if.master bus
);

    state_t     state;
    logic [2:0] bit_cnt;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] shadow;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    logic       en;
    logic       qtick;
    logic [1:0] phase;
    logic       smp;
    logic       bit_end;
    logic [7:0] tx_byte;
    logic       scl;
    logic       grab;
    logic       sda;

    assign en = (state != ST_IDLE) && (state != ST_DONE);

    iic_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .qtick (qtick),
        .phase (phase)
    );

    // Sample at the end of the first SCL-high quarter, advance at the end of the bit.
    assign smp     = qtick && (phase == 2'd2);
    assign bit_end = qtick && (phase == 2'd3);
    assign tx_byte = (state == ST_WDATA) ? wdata_q : addr_byte(addr_q, rw_q);

    always_comb begin
        scl  = 1'b1;
        grab = 1'b0;
        sda  = IDLE_SDA;
        case (state)
            ST_START: begin
                scl  = ~phase[1];
                grab = 1'b1;
                sda  = 1'b0;
            end
            ST_ADDR, ST_WDATA: begin
                scl  = phase[1];
                grab = 1'b1;
                sda  = tx_byte[bit_cnt];
            end
            ST_ACK_A, ST_ACK_W, ST_RDATA, ST_NACK_R: begin
                scl = phase[1];
            end
            ST_STOP: begin
                // SDA rises in the last quarter while SCL is high: the STOP condition.
                scl  = phase[1];
                grab = (phase != 2'd3);
                sda  = (phase == 2'd3) ? IDLE_SDA : 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            rw_q    <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 8'd0;
            shadow  <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (bus.go) begin
                    state   <= ST_START;
                    busy    <= 1'b1;
                    ack_err <= 1'b0;
                    rw_q    <= bus.rw;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                end
                ST_START: if (bit_end) begin
                    state   <= ST_ADDR;
                    bit_cnt <= 3'd7;
                end
                ST_ADDR: if (bit_end) begin
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state <= ST_ACK_A;
                end
                ST_ACK_A: begin
                    if (smp) ack_err <= bus.SDA_recv;
                    if (bit_end) state <= ack_err ? ST_STOP : (rw_q ? ST_RDATA : ST_WDATA);
                end
                ST_WDATA: if (bit_end) begin
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state <= ST_ACK_W;
                end
                ST_ACK_W: begin
                    if (smp) ack_err <= bus.SDA_recv;
                    if (bit_end) state <= ST_STOP;
                end
                ST_RDATA: begin
                    if (smp) shadow <= {shadow[6:0], bus.SDA_recv};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) state <= ST_NACK_R;
                    end
                end
                ST_NACK_R: if (bit_end) state <= ST_STOP;
                ST_STOP:   if (bit_end) state <= ST_DONE;
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (rw_q && !ack_err) rdata <= shadow;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SCL       = scl;
    assign bus.grab_SDA  = grab;
    assign bus.SDA_drive = sda;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ack_err   = ack_err;
    assign bus.rdata     = rdata;

endmodule

// File: tb/tb_iic_master.sv
// Bench for iic_master: a per-cycle waveform model built from bit symbols,
// a bus-level monitor for DUT4, and two instances (CLK_DIV=4 and CLK_DIV=1).
module tb_iic_master;
    import iic_pkg::*;

    typedef struct packed {
        logic       scl;
        logic       grab;
        logic       drv;
        logic       busy;
        logic       done;
        logic       tlow;
        logic       ack;
        logic       upd;
        logic [7:0] rd;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iic_master_if bus4 ();
    iic_master_if bus1 ();

    iic_master #(.CLK_DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    iic_master #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic       go_v[2];
    logic       rw_v[2];
    logic [6:0] addr_v[2];
    logic [7:0] wdata_v[2];
    logic       tlow[2];

    assign bus4.go       = go_v[0];
    assign bus4.rw       = rw_v[0];
    assign bus4.addr     = addr_v[0];
    assign bus4.wdata    = wdata_v[0];
    assign bus4.SDA_recv = (~bus4.grab_SDA | bus4.SDA_drive) & ~tlow[0];
    assign bus1.go       = go_v[1];
    assign bus1.rw       = rw_v[1];
    assign bus1.addr     = addr_v[1];
    assign bus1.wdata    = wdata_v[1];
    assign bus1.SDA_recv = (~bus1.grab_SDA | bus1.SDA_drive) & ~tlow[1];

    logic       scl_o[2], grab_o[2], drv_o[2], busy_o[2], done_o[2], aerr_o[2];
    logic [7:0] rdata_o[2];
    assign scl_o[0] = bus4.SCL;       assign scl_o[1] = bus1.SCL;
    assign grab_o[0] = bus4.grab_SDA; assign grab_o[1] = bus1.grab_SDA;
    assign drv_o[0] = bus4.SDA_drive; assign drv_o[1] = bus1.SDA_drive;
    assign busy_o[0] = bus4.busy;     assign busy_o[1] = bus1.busy;
    assign done_o[0] = bus4.done;     assign done_o[1] = bus1.done;
    assign aerr_o[0] = bus4.ack_err;  assign aerr_o[1] = bus1.ack_err;
    assign rdata_o[0] = bus4.rdata;   assign rdata_o[1] = bus1.rdata;

    int checks = 0;
    int errors = 0;

    task automatic note_fail(string name, int k, int act, int exp);
        errors++;
        if (errors <= 30)
            $display("FAIL %s dut%0d actual 0x%0h required 0x%0h", name, k, act, exp);
    endtask

    task automatic chk1(string name, int k, logic act, logic exp);
        checks++;
        if (act !== exp) note_fail(name, k, int'(act), int'(exp));
    endtask

    task automatic chk8(string name, int k, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) note_fail(name, k, int'(act), int'(exp));
    endtask

    task automatic chkn(string name, int k, int act, int exp);
        checks++;
        if (act != exp) note_fail(name, k, act, exp);
    endtask

    // ---------------- waveform model ----------------
    rec_t bq[$];
    rec_t q0[$];
    rec_t q1[$];
    logic [7:0] exp_rd[2];

    function automatic int dk(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // kind: 0 START, 1 master-sent bit, 2 target-side bit (master released), 3 STOP
    task automatic add_bit(int d, int kind, logic b);
        rec_t r;
        for (int q = 0; q < 4; q++) begin
            for (int c = 0; c < d; c++) begin
                r      = '0;
                r.busy = 1'b1;
                r.scl  = (kind == 0) ? (q < 2) : (q >= 2);
                r.grab = (kind == 0) || (kind == 1) || ((kind == 3) && (q < 3));
                r.drv  = (kind == 1) ? b : 1'b0;
                r.tlow = (kind == 2) && !b;
                bq.push_back(r);
            end
        end
    endtask

    task automatic build(int d, logic [6:0] a, logic r_w, logic [7:0] wd,
                         logic ack_a, logic ack_w, logic [7:0] rb);
        logic [7:0] ab;
        logic       aerr;
        rec_t       r;
        ab = {a, r_w};
        bq.delete();
        add_bit(d, 0, 1'b0);
        for (int i = 7; i >= 0; i--) add_bit(d, 1, ab[i]);
        add_bit(d, 2, !ack_a);
        if (ack_a && r_w) begin
            for (int i = 7; i >= 0; i--) add_bit(d, 2, rb[i]);
            add_bit(d, 2, 1'b1);
        end else if (ack_a) begin
            for (int i = 7; i >= 0; i--) add_bit(d, 1, wd[i]);
            add_bit(d, 2, !ack_w);
        end
        add_bit(d, 3, 1'b0);
        aerr   = !ack_a || (!r_w && !ack_w);
        r      = '0;
        r.scl  = 1'b1;
        r.busy = 1'b1;
        bq.push_back(r);
        r.busy = 1'b0;
        r.done = 1'b1;
        r.ack  = aerr;
        r.upd  = r_w && !aerr;
        r.rd   = rb;
        bq.push_back(r);
    endtask

    // ---------------- bus monitor (DUT4) ----------------
    logic mon_bits[$];
    int   start_seen = 0;
    int   stop_seen  = 0;
    logic prev_scl   = 1'b1;
    logic prev_sda   = 1'b1;

    function automatic logic [7:0] mon_byte(int off);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            if (off + i < mon_bits.size()) b[7-i] = mon_bits[off+i];
        return b;
    endfunction

    // ---------------- per-cycle compare ----------------
    rec_t cr;
    logic have;
    always @(negedge clk) begin
        if (prev_scl && bus4.SCL && prev_sda && !bus4.SDA_recv) begin
            mon_bits.delete();
            start_seen++;
        end else if (prev_scl && bus4.SCL && !prev_sda && bus4.SDA_recv) begin
            stop_seen++;
        end
        if (!prev_scl && bus4.SCL) mon_bits.push_back(bus4.SDA_recv);
        prev_scl = bus4.SCL;
        prev_sda = bus4.SDA_recv;

        for (int k = 0; k < 2; k++) begin
            have = 1'b0;
            if (k == 0 && q0.size() > 0) begin cr = q0.pop_front(); have = 1'b1; end
            if (k == 1 && q1.size() > 0) begin cr = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                cr     = '0;
                cr.scl = 1'b1;
                cr.drv = 1'b1;
            end
            tlow[k] = cr.tlow;
            if (have && cr.upd) exp_rd[k] = cr.rd;
            chk1("scl", k, scl_o[k], cr.scl);
            chk1("grab_sda", k, grab_o[k], cr.grab);
            if (cr.grab || !have) chk1("sda_drive", k, drv_o[k], cr.drv);
            chk1("busy", k, busy_o[k], cr.busy);
            chk1("done", k, done_o[k], cr.done);
            chk8("rdata", k, rdata_o[k], exp_rd[k]);
            if (have && cr.done) chk1("ack_err", k, aerr_o[k], cr.ack);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(int k, logic [6:0] a, logic r_w, logic [7:0] wd,
                         logic ack_a, logic ack_w, logic [7:0] rb);
        build(dk(k), a, r_w, wd, ack_a, ack_w, rb);
        go_v[k]    = 1'b1;
        rw_v[k]    = r_w;
        addr_v[k]  = a;
        wdata_v[k] = wd;
        @(posedge clk);
        #1;
        foreach (bq[i]) begin
            if (k == 0) q0.push_back(bq[i]);
            else        q1.push_back(bq[i]);
        end
    endtask

    // Wiggles go and the data inputs while busy; returns cycles from go to done.
    task automatic wait_done(int k, logic keep_go, output int n);
        n = 1;
        while (!done_o[k] && n < 2000) begin
            go_v[k]    = 1'($urandom_range(0, 1));
            rw_v[k]    = 1'($urandom_range(0, 1));
            addr_v[k]  = 7'($urandom);
            wdata_v[k] = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_o[k]) begin
            checks++;
            note_fail("done_timeout", k, n, 0);
        end
        go_v[k] = keep_go;
    endtask

    int n;
    int s0;

    initial begin
        #500000;
        $display("FAIL watchdog dut0 actual timeout required finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            go_v[k] = 1'b0; rw_v[k] = 1'b0; addr_v[k] = 7'd0; wdata_v[k] = 8'd0;
            tlow[k] = 1'b0; exp_rd[k] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_scl", 0, scl_o[0], 1'b1);
        chk1("rst_sda_drive", 0, drv_o[0], 1'b1);
        chk8("rst_rdata", 1, rdata_o[1], 8'h00);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write 0xA5 to address 69, both bytes acknowledged
        s0 = stop_seen;
        start(0, DEFAULT_ADDR, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        chkn("model_len_d4", 0, bq.size(), 322);
        wait_done(0, 1'b0, n);
        chkn("write_cycles", 0, n, 322);
        chk1("write_done", 0, done_o[0], 1'b1);
        chk1("write_ack_err", 0, aerr_o[0], 1'b0);
        chk8("write_addr_byte", 0, mon_byte(0), 8'h8A);
        chk1("write_ack_a", 0, mon_bits[8], 1'b0);
        chk8("write_data_byte", 0, mon_byte(9), 8'hA5);
        chkn("write_bits", 0, mon_bits.size(), 19);
        chkn("write_stop", 0, stop_seen, s0 + 1);
        repeat (3) @(posedge clk);
        #1;

        // Read from address 69, target returns 0x81
        start(0, DEFAULT_ADDR, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81);
        wait_done(0, 1'b0, n);
        chkn("read_cycles", 0, n, 322);
        chk8("read_rdata", 0, rdata_o[0], 8'h81);
        chk1("read_ack_err", 0, aerr_o[0], 1'b0);
        chk8("read_addr_byte", 0, mon_byte(0), 8'h8B);
        chk8("read_data_byte", 0, mon_byte(9), 8'h81);
        chk1("read_nack", 0, mon_bits[17], 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Unacknowledged address: no data byte, STOP right after ACK_A
        s0 = stop_seen;
        start(0, 7'h12, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hFF);
        wait_done(0, 1'b0, n);
        chkn("noack_cycles", 0, n, 178);
        chk1("noack_ack_err", 0, aerr_o[0], 1'b1);
        chk8("noack_rdata_kept", 0, rdata_o[0], 8'h81);
        chkn("noack_bits", 0, mon_bits.size(), 10);
        chk1("noack_bit8", 0, mon_bits[8], 1'b1);
        chkn("noack_stop", 0, stop_seen, s0 + 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of the 4th address bit (SCL low quarter)
        s0 = stop_seen;
        go_v[0] = 1'b1;
        start(0, DEFAULT_ADDR, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00);
        go_v[0] = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        chkn("pre_reset_bits", 0, mon_bits.size(), 3);
        chk8("pre_reset_prefix", 0, mon_byte(0), 8'h80);
        chk1("pre_reset_scl_low", 0, scl_o[0], 1'b0);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        tlow[0] = 1'b0;
        exp_rd[0] = 8'h00;
        #1;
        chk1("async_rst_scl", 0, scl_o[0], 1'b1);
        chk1("async_rst_grab", 0, grab_o[0], 1'b0);
        chk1("async_rst_busy", 0, busy_o[0], 1'b0);
        chk8("async_rst_rdata", 0, rdata_o[0], 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chkn("reset_no_stop", 0, stop_seen, s0);

        // After reset: write with data byte NACKed
        start(0, DEFAULT_ADDR, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00);
        wait_done(0, 1'b0, n);
        chkn("post_reset_cycles", 0, n, 322);
        chk1("ackw_err", 0, aerr_o[0], 1'b1);
        chk8("post_reset_data_byte", 0, mon_byte(9), 8'h5A);
        repeat (3) @(posedge clk);
        #1;

        // CLK_DIV=1, go held across two back-to-back transfers
        start(1, DEFAULT_ADDR, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
        chkn("model_len_d1", 1, bq.size(), 82);
        wait_done(1, 1'b1, n);
        chkn("b2b_first_cycles", 1, n, 82);
        chk8("b2b_first_rdata", 1, rdata_o[1], 8'h3C);
        start(1, 7'h45, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
        wait_done(1, 1'b0, n);
        chkn("b2b_second_cycles", 1, n, 82);
        chk1("b2b_second_ack_err", 1, aerr_o[1], 1'b0);
        chk8("b2b_rdata_kept", 1, rdata_o[1], 8'h3C);
        repeat (5) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
